imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion of instruction_memory: streams a program image in as bytes, assembles
//  little-endian 32-bit words and writes them into the instruction memory write port.
//  Pads every unloaded word with NOP (addi x0,x0,0 = 0x00000013) and holds the pipeline
//  core in reset until the image is complete.
// PARAMETERS
//  DEPTH   256  instruction memory depth in 32-bit words (power of two)
//  ADDR_W  8    word-index width, log2(DEPTH)
// PORTS
//  clk         in   1         single clock, all state updates on rising edge
//  reset       in   1         synchronous, active-high reset
//  start       in   1         one-cycle pulse: begin load; ignored while busy=1
//  word_count  in   ADDR_W+1  number of program words to receive, sampled on accepted start
//  byte_in     in   8         program byte stream, least-significant byte of each word first
//  byte_valid  in   1         byte_in valid
//  byte_ready  out  1         loader accepts byte; transfer when byte_valid && byte_ready
//  mem_we      out  1         instruction memory write enable, one word per cycle
//  mem_waddr   out  32        byte address, word aligned: {word_idx, 2'b00}, upper bits 0
//  mem_wdata   out  32        word to write
//  cpu_hold    out  1         1 = core held in reset
//  busy        out  1         load or fill in progress
//  done        out  1         image complete; memory fully written
//  checksum    out  32        mod-2^32 sum of received words (fill words excluded)
// BEHAVIOUR
//  Reset: state IDLE; byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0,
//   checksum=0, cpu_hold=1. Byte lane and word index cleared; partial word discarded.
//   Words already written stay in memory. Reset overrides all other inputs.
//  States: IDLE, RECV, WRITE, FILL, DONE.
//  IDLE/DONE + start: latch n = min(word_count, DEPTH); word_idx=0, lane=0, checksum=0,
//   done=0, busy=1, cpu_hold=1. Go to RECV if n>0, else FILL.
//  RECV: byte_ready=1. Each transfer stores byte_in into lane (lane0 -> [7:0] ... lane3 ->
//   [31:24]) and increments lane. Transfer on lane 3 -> WRITE next cycle. byte_valid low
//   stalls indefinitely with no state change.
//  WRITE (exactly 1 cycle): byte_ready=0, mem_we=1, mem_waddr={word_idx,2'b00},
//   mem_wdata=assembled word; checksum += word. Then word_idx++, lane=0.
//   If new word_idx==n: FILL if n<DEPTH, else DONE. Otherwise RECV.
//  FILL: mem_we=1 every cycle, mem_wdata=32'h00000013, mem_waddr increments by 4 from
//   {n,2'b00} to {DEPTH-1,2'b00}; after write of index DEPTH-1 -> DONE.
//  DONE: busy=0, done=1, cpu_hold=0, mem_we=0, byte_ready=0; held until next start or reset.
//  mem_we never asserted outside WRITE/FILL. word_idx never wraps (terminates at DEPTH).
//  Latency, continuous byte_valid: first write 5 cycles after start-accept cycle (4 accepts
//   + WRITE); 5 cycles per word; then DEPTH-n fill cycles; done rises the cycle after the
//   last write. Total = 5n + (DEPTH-n) + 2 cycles from start to done (start cycle included).
//  start while busy=1: ignored, no effect on n, checksum or counters.
//  word_count > DEPTH: clamped to DEPTH; no fill phase.
//  Outputs all registered.
// TESTING
//  T1 reset: hold reset 3 cycles with start=1, byte_valid=1 -> cpu_hold=1, all other outputs 0,
//   no mem_we pulse.
//  T2 10-word image, first bytes 93 00 A0 00 -> write 0x00A00093 @0x000; word9 @0x024;
//   then 246 NOP writes 0x028..0x3FC; done=1, cpu_hold=0, checksum = sum of the 10 words.
//  T3 same image, byte_valid toggling 1/0 each cycle -> identical write sequence and
//   checksum; no byte lost or duplicated; byte_ready=0 during WRITE and FILL.
//  T4 word_count=0 -> no byte accepted, 256 NOP writes 0x000..0x3FC, checksum=0, done=1.
//  T5 word_count=300 -> exactly 256 words received, no fill cycles, done after write @0x3FC.
//  T6 reset after 2 bytes of word 3 -> no write for word 3, IDLE, cpu_hold=1; a new
//   start reloads from @0x000; start pulsed mid-load is ignored.

Source files
------------

// File: rtl/imem_loader.sv
// Streams a program image in as bytes, assembles little-endian words and writes them into
// instruction memory, NOP-filling the remainder and holding the core in reset until complete.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, FILL, DONE} state_t;

  state_t          state, state_n;
  logic [ADDR_W:0] n, n_n, idx, idx_n;
  logic [1:0]      lane, lane_n;
  logic [31:0]     word, word_n;
  logic            we_n;

  always_comb begin
    state_n = state;
    n_n     = n;
    idx_n   = idx;
    lane_n  = lane;
    word_n  = word;
    case (state)
      IDLE, DONE: if (start) begin
        n_n     = (word_count > DEPTH_C) ? DEPTH_C : word_count;
        idx_n   = '0;
        lane_n  = '0;
        state_n = (n_n == '0) ? FILL : RECV;
      end
      RECV: if (byte_valid) begin
        word_n[8*lane +: 8] = byte_in;
        lane_n              = lane + 2'd1;
        if (lane == 2'd3) state_n = WRITE;
      end
      WRITE: begin
        idx_n  = idx + ONE_C;
        lane_n = '0;
        if (idx_n == n) state_n = (n < DEPTH_C) ? FILL : DONE;
        else            state_n = RECV;
      end
      FILL: begin
        // idx always names the word being written this cycle
        if (idx == LAST_C) state_n = DONE;
        else               idx_n   = idx + ONE_C;
      end
      default: state_n = IDLE;
    endcase
    we_n = (state_n == WRITE) || (state_n == FILL);
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n          <= '0;
      idx        <= '0;
      lane       <= '0;
      word       <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
      checksum   <= '0;
    end else begin
      state      <= state_n;
      n          <= n_n;
      idx        <= idx_n;
      lane       <= lane_n;
      word       <= word_n;
      byte_ready <= (state_n == RECV);
      mem_we     <= we_n;
      mem_waddr  <= we_n ? {{(30-ADDR_W){1'b0}}, idx_n[ADDR_W-1:0], 2'b00} : '0;
      mem_wdata  <= (state_n == WRITE) ? word_n : (state_n == FILL) ? NOP : '0;
      busy       <= (state_n == RECV) || (state_n == WRITE) || (state_n == FILL);
      done       <= (state_n == DONE);
      cpu_hold   <= (state_n != DONE);
      if ((state == IDLE || state == DONE) && start) checksum <= '0;
      else if (state == WRITE)                       checksum <= checksum + word;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streaming, NOP fill, clamping, mid-load reset.
module tb_imem_loader;
  localparam int          DEPTH  = 256;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset, start, byte_valid;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_in;
  logic              byte_ready, mem_we, cpu_hold, busy, done;
  logic [31:0]       mem_waddr, mem_wdata, checksum;

  int tests = 0;
  int fails = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int acc  = 0;
  int viol = 0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum)
  );

  // write/byte monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
    end
    if (byte_valid && byte_ready) acc++;
    if (mem_we && (byte_ready || !busy || done)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // addi x1, x0, 10+i  (word 0 = 0x00A00093)
  function automatic logic [31:0] word_of(input int i);
    logic [11:0] imm;
    imm = 12'(10 + i);
    return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  function automatic logic [7:0] byte_of(input int b);
    logic [31:0] w;
    w = word_of(b / 4);
    return w[8*(b%4) +: 8];
  endfunction

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    acc  = 0;
    viol = 0;
  endtask

  task automatic pulse_start(input int wc);
    word_count = (ADDR_W+1)'(wc);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send(input int first, input int nb, input bit tog);
    int b   = first;
    int cyc = 0;
    bit ph  = 1'b1;
    bit x;
    while (b < first + nb && cyc < 4000) begin
      byte_valid = tog ? ph : 1'b1;
      byte_in    = byte_of(b);
      @(negedge clk);
      x = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (x) b++;
      ph = !ph;
      cyc++;
    end
    byte_valid = 1'b0;
    chk("send_timeout", 32'(b), 32'(first + nb));
  endtask

  // cycles counted from the start-accept edge to the edge after which done is visible
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      cyc++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic verify(input string tag, input int n);
    int          errs = 0;
    logic [31:0] sum  = '0;
    logic [31:0] exp;
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < n) ? word_of(i) : NOP;
      if (i < n) sum = sum + word_of(i);
      if (i < wa_q.size())
        if (wa_q[i] !== 32'(i*4) || wd_q[i] !== exp) errs++;
    end
    chk({tag, "_seq"}, 32'(errs), 32'd0);
    chk({tag, "_viol"}, 32'(viol), 32'd0);
    chk({tag, "_flags"}, {29'd0, done, busy, cpu_hold}, 32'b100);
    chk({tag, "_csum"}, checksum, sum);
  endtask

  initial begin
    int lat;
    int errs;
    // T1: reset held with start and byte_valid asserted
    reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hFF; word_count = 9'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("T1_hold", 32'(cpu_hold), 32'd1);
    chk("T1_ctl", {27'd0, byte_ready, mem_we, busy, done, 1'b0}, 32'd0);
    chk("T1_waddr", mem_waddr, 32'd0);
    chk("T1_wdata", mem_wdata, 32'd0);
    chk("T1_csum", checksum, 32'd0);
    chk("T1_nwr", 32'(wa_q.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    chk("T1_idle", {29'd0, busy, done, cpu_hold}, 32'b001);

    // T2: 10-word image, continuous bytes
    clr();
    pulse_start(10);
    fork
      send(0, 40, 1'b0);
      wait_done(lat);
    join
    chk("T2_lat", 32'(lat), 32'd296);
    chk("T2_acc", 32'(acc), 32'd40);
    verify("T2", 10);
    chk("T2_csum_k", checksum, 32'h0910_05BE);
    if (wa_q.size() == DEPTH) begin
      chk("T2_w0a", wa_q[0], 32'h000);
      chk("T2_w0d", wd_q[0], 32'h00A0_0093);
      chk("T2_w9a", wa_q[9], 32'h024);
      chk("T2_w9d", wd_q[9], 32'h0130_0093);
      chk("T2_f0a", wa_q[10], 32'h028);
      chk("T2_f0d", wd_q[10], NOP);
      chk("T2_lasta", wa_q[255], 32'h3FC);
    end

    // T3: same image, byte_valid toggling
    clr();
    pulse_start(10);
    fork
      send(0, 40, 1'b1);
      wait_done(lat);
    join
    chk("T3_acc", 32'(acc), 32'd40);
    verify("T3", 10);
    chk("T3_csum_k", checksum, 32'h0910_05BE);

    // T4: empty image, bytes offered but never accepted
    clr();
    byte_valid = 1'b1; byte_in = 8'hAA;
    pulse_start(0);
    wait_done(lat);
    byte_valid = 1'b0;
    chk("T4_lat", 32'(lat), 32'd256);
    chk("T4_acc", 32'(acc), 32'd0);
    verify("T4", 0);

    // T5: oversized count clamps to DEPTH, no fill
    clr();
    pulse_start(300);
    fork
      send(0, 4*DEPTH, 1'b0);
      wait_done(lat);
    join
    chk("T5_lat", 32'(lat), 32'd1280);
    chk("T5_acc", 32'(acc), 32'(4*DEPTH));
    verify("T5", DEPTH);

    // T6: ignored mid-load start, then reset inside word 3
    clr();
    pulse_start(10);
    send(0, 8, 1'b0);
    pulse_start(2);
    send(8, 6, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("T6_nwr", 32'(wa_q.size()), 32'd3);
    errs = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 32'(i*4) || wd_q[i] !== word_of(i)) errs++;
    chk("T6_seq", 32'(errs), 32'd0);
    chk("T6_state", {27'd0, byte_ready, mem_we, busy, done, cpu_hold}, 32'b00001);
    chk("T6_csum", checksum, 32'd0);
    clr();
    pulse_start(10);
    fork
      send(0, 40, 1'b0);
      wait_done(lat);
    join
    chk("T6_lat", 32'(lat), 32'd296);
    verify("T6b", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
